// File: rtl/bullet_pool_pkg.sv
// Shared types for the projectile pool: travel direction, ammo FSM states,
// coordinate width and the per-slot bullet record.
// Also provides widen(), which zero-extends a coordinate by one bit for compares that must not wrap.
package bullet_pool_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    EMPTY  = 2'd1,
    RELOAD = 2'd2
  } ammo_state_t;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    dir_t               dir;
  } bullet_t;

  // One extra bit of headroom so edge tests cannot overflow or underflow.
  function automatic logic [COORD_W:0] widen(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Fire/bullet bus between the player controller (master) and the bullet pool (slave).
// Inputs: shoot, reload, Direction, BallX, BallY. Outputs: bullet_active/x/y, ammo, reloading, fire_accept, fire_reject.
// With BULLET_PIXEL_QUERY_EN defined, DrawX/DrawY go in and is_bullet comes back.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4
);
  logic                      shoot;
  logic                      reload;
  logic [1:0]                Direction;
  logic [9:0]                BallX;
  logic [9:0]                BallY;
  logic [NUM_BULLETS-1:0]    bullet_active;
  logic [10*NUM_BULLETS-1:0] bullet_x;
  logic [10*NUM_BULLETS-1:0] bullet_y;
  logic [3:0]                ammo;
  logic                      reloading;
  logic                      fire_accept;
  logic                      fire_reject;

`ifdef BULLET_PIXEL_QUERY_EN
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_bullet;

  modport master (
    output shoot, reload, Direction, BallX, BallY, DrawX, DrawY,
    input  bullet_active, bullet_x, bullet_y, ammo, reloading, fire_accept, fire_reject, is_bullet
  );
  modport slave (
    input  shoot, reload, Direction, BallX, BallY, DrawX, DrawY,
    output bullet_active, bullet_x, bullet_y, ammo, reloading, fire_accept, fire_reject, is_bullet
  );
`else
  modport master (
    output shoot, reload, Direction, BallX, BallY,
    input  bullet_active, bullet_x, bullet_y, ammo, reloading, fire_accept, fire_reject
  );
  modport slave (
    input  shoot, reload, Direction, BallX, BallY,
    output bullet_active, bullet_x, bullet_y, ammo, reloading, fire_accept, fire_reject
  );
`endif

endinterface

// File: rtl/bullet_pool_slot.sv
// One projectile slot: latches the spawn point, then steps once per frame and retires at the screen edge.
// Ports: frame_clk, Reset (async, active-high), spawn + spawn_x/spawn_y/spawn_dir in; active, x, y out.
// Spawn is only issued to an idle slot, so spawn and move never collide.
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int BULLET_STEP = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  dir_t               spawn_dir,
  output logic               active,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam int WIDE_W = COORD_W + 1;
  localparam logic [WIDE_W-1:0] STEP = WIDE_W'(BULLET_STEP);
  localparam logic [WIDE_W-1:0] XLIM = WIDE_W'(X_MAX);
  localparam logic [WIDE_W-1:0] YLIM = WIDE_W'(Y_MAX);

  bullet_t           state;
  bullet_t           moved;
  logic [WIDE_W-1:0] xw;
  logic [WIDE_W-1:0] yw;

  assign xw = widen(state.x);
  assign yw = widen(state.y);

  // A step that would leave the screen retires the slot; the position keeps its last legal value.
  always_comb begin
    moved = state;
    case (state.dir)
      DIR_LEFT:  if (xw < STEP)        moved.active = 1'b0; else moved.x = COORD_W'(xw - STEP);
      DIR_RIGHT: if (xw + STEP > XLIM) moved.active = 1'b0; else moved.x = COORD_W'(xw + STEP);
      DIR_DOWN:  if (yw + STEP > YLIM) moved.active = 1'b0; else moved.y = COORD_W'(yw + STEP);
      DIR_UP:    if (yw < STEP)        moved.active = 1'b0; else moved.y = COORD_W'(yw - STEP);
      default:   moved = state;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= '0;
    end else if (spawn) begin
      state <= '{active: 1'b1, x: spawn_x, y: spawn_y, dir: spawn_dir};
    end else if (state.active) begin
      state <= moved;
    end
  end

  assign active = state.active;
  assign x      = state.x;
  assign y      = state.y;

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: fire edge detect, ammo/reload FSM, lowest-free-slot spawn, NUM_BULLETS moving slots.
// Ports: Reset (async, active-high), frame_clk, bus (bullet_pool_if.slave) carrying fire inputs and pool state.
// Optional BULLET_PIXEL_QUERY_EN adds a combinational DrawX/DrawY -> is_bullet hit test.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int NUM_BULLETS   = 4,
  parameter int BULLET_STEP   = 4,
  parameter int AMMO_MAX      = 6,
  parameter int RELOAD_FRAMES = 30,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479
`ifdef BULLET_PIXEL_QUERY_EN
  , parameter int BULLET_SIZE = 2
`endif
) (
  input logic          Reset,
  input logic          frame_clk,
  bullet_pool_if.slave bus
);

  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CNT_W = (RELOAD_FRAMES > 1) ? $clog2(RELOAD_FRAMES) : 1;
  localparam logic [3:0]       AMMO_FULL = 4'(AMMO_MAX);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(RELOAD_FRAMES - 1);

  ammo_state_t        state_q, state_d;
  logic               shoot_q;
  logic               fire_ev;
  logic [3:0]         ammo_q, ammo_d, ammo_post;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept_d, reject_d, accept_q, reject_q;
  logic               can_spawn, reload_go;
  logic [IDX_W-1:0]   free_idx;
  logic               have_free;

  logic [NUM_BULLETS-1:0] slot_active;
  logic [COORD_W-1:0]     slot_x [NUM_BULLETS];
  logic [COORD_W-1:0]     slot_y [NUM_BULLETS];

  assign fire_ev = bus.shoot & ~shoot_q;

  // Lowest-index idle slot as of the start of the frame; a slot retiring this frame still reads active.
  always_comb begin
    free_idx  = '0;
    have_free = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_idx  = IDX_W'(i);
        have_free = 1'b1;
      end
    end
  end

  // Fire resolves first; reload is then judged against the ammo left after that fire.
  assign can_spawn = (state_q == READY) && fire_ev && have_free && (ammo_q != 4'd0);
  assign ammo_post = can_spawn ? ammo_q - 4'd1 : ammo_q;
  assign reload_go = bus.reload && (ammo_post < AMMO_FULL) && (state_q != RELOAD);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_q <= READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (reload_go) state_d = RELOAD; else if (ammo_post == 4'd0) state_d = EMPTY;
      EMPTY:   if (reload_go) state_d = RELOAD;
      RELOAD:  if (cnt_q == '0) state_d = READY;
      default: state_d = READY;
    endcase
  end

  always_comb begin
    accept_d = can_spawn;
    reject_d = fire_ev & ~can_spawn;
    ammo_d   = ammo_post;
    cnt_d    = cnt_q;
    case (state_q)
      READY, EMPTY: if (reload_go) cnt_d = CNT_INIT;
      RELOAD: begin
        if (cnt_q == '0) ammo_d = AMMO_FULL;
        else             cnt_d  = cnt_q - CNT_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      shoot_q  <= 1'b0;
      ammo_q   <= AMMO_FULL;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      shoot_q  <= bus.shoot;
      ammo_q   <= ammo_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_pool_slot #(
      .BULLET_STEP(BULLET_STEP),
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .spawn    (accept_d && (free_idx == IDX_W'(i))),
      .spawn_x  (bus.BallX),
      .spawn_y  (bus.BallY),
      .spawn_dir(dir_t'(bus.Direction)),
      .active   (slot_active[i]),
      .x        (slot_x[i]),
      .y        (slot_y[i])
    );
  end

  logic [COORD_W*NUM_BULLETS-1:0] x_flat, y_flat;
  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_flat[COORD_W*i +: COORD_W] = slot_x[i];
      y_flat[COORD_W*i +: COORD_W] = slot_y[i];
    end
  end

  assign bus.bullet_active = slot_active;
  assign bus.bullet_x      = x_flat;
  assign bus.bullet_y      = y_flat;
  assign bus.ammo          = ammo_q;
  assign bus.reloading     = (state_q == RELOAD);
  assign bus.fire_accept   = accept_q;
  assign bus.fire_reject   = reject_q;

`ifdef BULLET_PIXEL_QUERY_EN
  localparam logic signed [COORD_W:0] SZ = (COORD_W + 1)'(BULLET_SIZE);
  logic signed [COORD_W:0] dx, dy;
  logic                    hit;

  // Signed 11-bit differences so a beam left/above the bullet gives a negative offset, not a wrap.
  always_comb begin
    hit = 1'b0;
    dx  = '0;
    dy  = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      dx = $signed(widen(bus.DrawX)) - $signed(widen(slot_x[i]));
      dy = $signed(widen(bus.DrawY)) - $signed(widen(slot_y[i]));
      if (slot_active[i] && (dx <= SZ) && (dx >= -SZ) && (dy <= SZ) && (dy >= -SZ)) hit = 1'b1;
    end
  end

  assign bus.is_bullet = hit;
`endif

endmodule
